// File: rtl/serial_nibble_receiver.sv
// Serial-to-parallel word receiver fed by the upstream shift register's S_OUT.
// Assembles WIDTH-bit words MSB- or LSB-first, optionally framed by start/stop bits.
module serial_nibble_receiver #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             ENB,
    input  logic             S_IN,
    input  logic             DIR,
    input  logic             FRAMED,
    input  logic             RD,
    input  logic             CLR,
    output logic [WIDTH-1:0] Q,
    output logic             VALID,
    output logic             BUSY,
    output logic             OVERRUN,
    output logic             FRAME_ERR,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  sh;
    logic              dir_l;
    logic              framed_l;

    logic              dir_use;
    logic [WIDTH-1:0]  base;
    logic [WIDTH-1:0]  shifted;
    logic              last_data;
    logic              commit;
    logic              frame_set;
    logic              overrun_set;
    logic [WIDTH-1:0]  word;

    // The edge leaving IDLE uses the live DIR and starts from an empty register.
    always_comb begin
        dir_use     = (state == IDLE) ? DIR : dir_l;
        base        = (state == IDLE) ? '0 : sh;
        shifted     = dir_use ? {base[WIDTH-2:0], S_IN} : {S_IN, base[WIDTH-1:1]};
        last_data   = (state == DATA) && (cnt == CW'(WIDTH - 1));
        commit      = ENB && ((last_data && !framed_l) || ((state == STOP) && S_IN));
        word        = (state == STOP) ? sh : shifted;
        frame_set   = ENB && (state == STOP) && !S_IN;
        overrun_set = commit && VALID && !RD;
    end

    // Handshake: Q is valid while VALID=1; RD=1 on an edge with VALID=1 consumes it,
    // unless a new word commits on that same edge, in which case VALID stays high.
    always_ff @(posedge clk) begin
        if (RESET) begin
            state     <= IDLE;
            cnt       <= '0;
            sh        <= '0;
            dir_l     <= 1'b0;
            framed_l  <= 1'b0;
            Q         <= '0;
            VALID     <= 1'b0;
            OVERRUN   <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else begin
            if (ENB) begin
                case (state)
                    IDLE: begin
                        if (!FRAMED) begin
                            state    <= DATA;
                            cnt      <= CW'(1);
                            sh       <= shifted;
                            dir_l    <= DIR;
                            framed_l <= 1'b0;
                        end else if (!S_IN) begin
                            state    <= DATA;
                            cnt      <= '0;
                            sh       <= '0;
                            dir_l    <= DIR;
                            framed_l <= 1'b1;
                        end
                    end
                    DATA: begin
                        sh <= shifted;
                        if (last_data) begin
                            cnt   <= '0;
                            state <= framed_l ? STOP : IDLE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    STOP: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end

            if (commit) begin
                Q     <= word;
                VALID <= 1'b1;
            end else if (RD) begin
                VALID <= 1'b0;
            end

            // Set events take priority over a simultaneous clear.
            if (overrun_set)   OVERRUN <= 1'b1;
            else if (CLR)      OVERRUN <= 1'b0;

            if (frame_set)     FRAME_ERR <= 1'b1;
            else if (CLR)      FRAME_ERR <= 1'b0;
        end
    end

    assign BUSY      = (state != IDLE);
    assign dbg_state = state;

endmodule
